bcd_clock: RTL and testbench



---
 rtl/bcd_clock_pkg.sv | 22 ++
 rtl/bcd_mod_counter.sv | 25 ++
 rtl/bcd_clock.sv | 82 ++++++++
 tb/tb_bcd_clock.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_clock_pkg.sv
// Shared constants and BCD helper for the time-of-day clock.
// 12-hour mode is selected with CLOCK_12H_EN.
package bcd_clock_pkg;

  localparam logic [7:0] SEC_MAX  = 8'h59;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] HR24_MAX = 8'h23;
  localparam logic [7:0] HR12_MAX = 8'h12;
  localparam logic [7:0] HR12_MIN = 8'h01;

  function automatic logic [7:0] bcd_inc(
    input logic [7:0] v
  );
    logic [7:0] r;
    if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that reloads after reaching its wrap value.
// Used for the seconds, minutes and hours fields of bcd_clock.
module bcd_mod_counter #(
  parameter logic [7:0] INIT = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic [7:0] wrap,
  input  logic [7:0] reload,
  output logic [7:0] q,
  output logic       at_max
);
  import bcd_clock_pkg::*;

  assign at_max = (q == wrap);

  always_ff @(posedge clk) begin
    if (!reset)
      q <= INIT;
    else if (inc)
      q <= at_max ? reload : bcd_inc(q);
  end

endmodule

// File: rtl/bcd_clock.sv
// BCD time-of-day clock, one second per enabled cycle.
// Define CLOCK_12H_EN for 12-hour mode with a pm output.
module bcd_clock (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss
`ifdef CLOCK_12H_EN
  ,
  output logic       pm
`endif
);
  import bcd_clock_pkg::*;

`ifdef CLOCK_12H_EN
  localparam logic [7:0] HR_WRAP = HR12_MAX;
  localparam logic [7:0] HR_LOAD = HR12_MIN;
  localparam logic [7:0] HR_INIT = HR12_MAX;
`else
  localparam logic [7:0] HR_WRAP = HR24_MAX;
  localparam logic [7:0] HR_LOAD = 8'h00;
  localparam logic [7:0] HR_INIT = 8'h00;
`endif

  logic ss_max;
  logic mm_max;
  logic mm_inc;
  logic hh_inc;
  logic hh_max_unused;

  assign mm_inc = ena & ss_max;
  assign hh_inc = mm_inc & mm_max;

  bcd_mod_counter #(
    .INIT(8'h00)
  ) u_ss (
    .clk   (clk),
    .reset (reset),
    .inc   (ena),
    .wrap  (SEC_MAX),
    .reload(8'h00),
    .q     (ss),
    .at_max(ss_max)
  );

  bcd_mod_counter #(
    .INIT(8'h00)
  ) u_mm (
    .clk   (clk),
    .reset (reset),
    .inc   (mm_inc),
    .wrap  (MIN_MAX),
    .reload(8'h00),
    .q     (mm),
    .at_max(mm_max)
  );

  bcd_mod_counter #(
    .INIT(HR_INIT)
  ) u_hh (
    .clk   (clk),
    .reset (reset),
    .inc   (hh_inc),
    .wrap  (HR_WRAP),
    .reload(HR_LOAD),
    .q     (hh),
    .at_max(hh_max_unused)
  );

`ifdef CLOCK_12H_EN
  // Flip only on 11 -> 12; the 12 -> 01 reload leaves pm alone.
  always_ff @(posedge clk) begin
    if (!reset)
      pm <= 1'b0;
    else if (hh_inc && bcd_inc(hh) == HR12_MAX)
      pm <= ~pm;
  end
`endif

endmodule

// File: tb/tb_bcd_clock.sv
// Randomized bench for bcd_clock against a seconds-since-midnight model.
// Build with CLOCK_12H_EN to exercise the 12-hour variant.
module tb_bcd_clock;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] hh;
  logic [7:0] mm;
  logic [7:0] ss;
  logic       pm;
  logic [23:0] now;

  int t = 0;
  int n_pass = 0;
  int n_total = 0;

`ifdef CLOCK_12H_EN
  localparam logic [7:0] HR0 = 8'h12;
  localparam logic [23:0] LAST = 24'h115959;
`else
  localparam logic [7:0] HR0 = 8'h00;
  localparam logic [23:0] LAST = 24'h235959;
  assign pm = 1'b0;
`endif

  assign now = {hh, mm, ss};

  always #5 clk = ~clk;

  bcd_clock dut (
    .clk  (clk),
    .reset(reset),
    .ena  (ena),
    .hh   (hh),
    .mm   (mm),
    .ss   (ss)
`ifdef CLOCK_12H_EN
    ,
    .pm   (pm)
`endif
  );

  function automatic logic [7:0] to_bcd(input int n);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = 4'(n / 10);
    units = 4'(n % 10);
    return {tens, units};
  endfunction

  function automatic logic [23:0] exp_time();
    int h;
    h = t / 3600;
`ifdef CLOCK_12H_EN
    h = h % 12;
    if (h == 0) h = 12;
`endif
    return {to_bcd(h), to_bcd((t / 60) % 60),
            to_bcd(t % 60)};
  endfunction

  function automatic logic exp_pm();
`ifdef CLOCK_12H_EN
    return t >= 43200;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit digits_ok(input logic [23:0] v);
    for (int i = 0; i < 6; i++) begin
      if ($isunknown(v[i*4 +: 4]) || v[i*4 +: 4] > 4'd9)
        return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic bit quiet();
    return (n_total - n_pass) > 20;
  endfunction

  task automatic tick(input logic r, input logic e);
    reset = r;
    ena = e;
    @(posedge clk);
    if (!r) t = 0;
    else if (e) t = (t + 1) % 86400;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b1);
      n_total++;
      if (now !== {HR0, 16'h0000}) begin
        $display("FAIL reset_val got %h want %h",
                 now, {HR0, 16'h0000});
      end else n_pass++;
      n_total++;
      if (pm !== 1'b0)
        $display("FAIL reset_pm got %b want 0", pm);
      else n_pass++;
    end
  endtask

  task automatic test_carry();
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b1);
      n_total++;
      if (now !== exp_time() || !digits_ok(now)) begin
        $display("FAIL carry got %h want %h",
                 now, exp_time());
      end else n_pass++;
    end
    n_total++;
    if (ss !== 8'h10)
      $display("FAIL carry_ss got %h want 10", ss);
    else n_pass++;
  endtask

  task automatic test_freeze();
    int guard = 0;
    while (t < 60 && guard < 1000) begin
      guard++;
      tick(1'b1, 1'($urandom_range(0, 2) != 0));
      n_total++;
      if (now !== exp_time() || !digits_ok(now)) begin
        $display("FAIL freeze ena=%b got %h want %h",
                 ena, now, exp_time());
      end else n_pass++;
    end
    n_total++;
    if (now !== {HR0, 16'h0100}) begin
      $display("FAIL minute got %h want %h",
               now, {HR0, 16'h0100});
    end else n_pass++;
  endtask

  task automatic test_hour();
    int guard = 0;
    while (t < 3600 && guard < 10000) begin
      guard++;
      tick(1'b1, 1'($urandom_range(0, 7) != 0));
      n_total++;
      if (now !== exp_time() || !digits_ok(now)) begin
        if (!quiet())
          $display("FAIL hour_run t=%0d got %h want %h",
                   t, now, exp_time());
      end else n_pass++;
    end
    n_total++;
    if (now !== 24'h010000)
      $display("FAIL hour got %h want 010000", now);
    else n_pass++;
  endtask

  task automatic test_day();
    bit saw_last = 1'b0;
    for (int i = 3600; i < 86400; i++) begin
      tick(1'b1, 1'b1);
      n_total++;
      if (now !== exp_time() || pm !== exp_pm() ||
          !digits_ok(now)) begin
        if (!quiet())
          $display("FAIL day t=%0d got %h/%b want %h/%b",
                   t, now, pm, exp_time(), exp_pm());
      end else n_pass++;
      if (t == 86399 && now === LAST && pm === exp_pm())
        saw_last = 1'b1;
`ifdef CLOCK_12H_EN
      if (t == 43200) begin
        n_total++;
        if (now !== 24'h120000 || pm !== 1'b1)
          $display("FAIL noon got %h/%b want 120000/1",
                   now, pm);
        else n_pass++;
      end
      if (t == 46800) begin
        n_total++;
        if (now !== 24'h010000 || pm !== 1'b1)
          $display("FAIL one_pm got %h/%b want 010000/1",
                   now, pm);
        else n_pass++;
      end
`endif
    end
    n_total++;
    if (!saw_last)
      $display("FAIL last_sec got 0 want 1");
    else n_pass++;
    n_total++;
    if (now !== {HR0, 16'h0000} || pm !== 1'b0) begin
      $display("FAIL midnight got %h/%b want %h/0",
               now, pm, {HR0, 16'h0000});
    end else n_pass++;
  endtask

  task automatic test_reset_mid();
    int n;
    n = $urandom_range(50, 200);
    for (int i = 0; i < n; i++) begin
      tick(1'b1, 1'($urandom_range(0, 3) != 0));
      n_total++;
      if (now !== exp_time() || !digits_ok(now)) begin
        $display("FAIL pre_reset got %h want %h",
                 now, exp_time());
      end else n_pass++;
    end
    tick(1'b0, 1'b1);
    n_total++;
    if (now !== {HR0, 16'h0000} || pm !== 1'b0) begin
      $display("FAIL mid_reset got %h/%b want %h/0",
               now, pm, {HR0, 16'h0000});
    end else n_pass++;
    tick(1'b1, 1'b1);
    n_total++;
    if (now !== {HR0, 16'h0001})
      $display("FAIL restart got %h want %h",
               now, {HR0, 16'h0001});
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_carry();
    test_freeze();
    test_hour();
    test_day();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
